// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned PC_W = 16;
    localparam logic [15:0] NOP_WORD = 16'h0000;
    localparam logic [15:0] HALT_WORD_DEFAULT = 16'hEFFF;

    typedef enum logic [0:0] {
        RUN,
        HALTED
    } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for the fetch stage: jump > branch > stall/halt hold > sequential.
module fetch_next_pc
    import fetch_pkg::*;
(
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] ifid_pc_plus2_i,
    input  logic            jump_valid_i,
    input  logic [PC_W-1:0] jump_target_i,
    input  logic            branch_taken_i,
    input  logic [7:0]      branch_offset_i,
    input  logic            stall_i,
    input  logic            hold_i,
    output logic [PC_W-1:0] next_pc_o,
    output logic            redirect_o
);

    logic [PC_W-1:0] branch_byte_off;
    logic [PC_W-1:0] branch_target;

    // Word offset -> byte offset: sign-extend then shift left by one.
    assign branch_byte_off = {{(PC_W-9){branch_offset_i[7]}}, branch_offset_i, 1'b0};
    assign branch_target   = ifid_pc_plus2_i + branch_byte_off;
    assign redirect_o      = jump_valid_i | branch_taken_i;

    always_comb begin
        next_pc_o = pc_i + 16'd2;
        if (jump_valid_i) begin
            next_pc_o = jump_target_i & ~16'h0001;
        end else if (branch_taken_i) begin
            next_pc_o = branch_target;
        end else if (stall_i || hold_i) begin
            next_pc_o = pc_i;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, IF/ID register, redirect/flush, range check and halt.
// Optional perf counters (perf_fetched, perf_stall) when FETCH_PERF_CNT_EN is defined.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int unsigned MEM_WORDS = 30,
    parameter logic [15:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [7:0]  branch_offset,
    input  logic        jump_valid,
    input  logic [15:0] jump_target,
    output logic [15:0] pc,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_stall
`endif
);

    localparam int unsigned MemBytes = 2 * MEM_WORDS;

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  instr_q, instr_d;
    logic [15:0]  pp2_q, pp2_d;
    logic         valid_q, valid_d;

    logic         in_range;
    logic [15:0]  fetched_word;
    logic         is_halt;
    logic         redirect;
    logic [15:0]  next_pc;

    assign in_range     = 32'(pc_q) < MemBytes;
    assign fetched_word = in_range ? imem_data : NOP_WORD;
    assign is_halt      = (fetched_word == HALT_WORD);

    fetch_next_pc u_next_pc (
        .pc_i            (pc_q),
        .ifid_pc_plus2_i (pp2_q),
        .jump_valid_i    (jump_valid),
        .jump_target_i   (jump_target),
        .branch_taken_i  (branch_taken),
        .branch_offset_i (branch_offset),
        .stall_i         (stall),
        .hold_i          (is_halt),
        .next_pc_o       (next_pc),
        .redirect_o      (redirect)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pp2_d   = pp2_q;
        valid_d = valid_q;
        unique case (state_q)
            RUN: begin
                if (redirect) begin
                    pc_d    = next_pc;
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    pc_d    = next_pc;
                    instr_d = fetched_word;
                    pp2_d   = pc_q + 16'd2;
                    valid_d = in_range;
                    if (is_halt) begin
                        state_d = HALTED;
                    end
                end
            end
            HALTED: begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pp2_q   <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pp2_q   <= pp2_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign ifid_instr    = instr_q;
    assign ifid_pc_plus2 = pp2_q;
    assign ifid_valid    = valid_q;
    assign halted        = (state_q == HALTED);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetched_q, perf_fetched_d;
    logic [15:0] perf_stall_q, perf_stall_d;
    logic        running;

    assign running = (state_q == RUN);

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        if (running && !redirect && !stall && in_range && perf_fetched_q != 16'hFFFF) begin
            perf_fetched_d = perf_fetched_q + 16'd1;
        end
        if (running && !redirect && stall && perf_stall_q != 16'hFFFF) begin
            perf_stall_d = perf_stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_q <= 16'h0000;
            perf_stall_q   <= 16'h0000;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage using an expected-result queue.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rst_w = 1'b0;
    logic [15:0] imem_addr, imem_data;
    logic        stall = 1'b0, branch_taken = 1'b0, jump_valid = 1'b0;
    logic [7:0]  branch_offset = 8'h00;
    logic [15:0] jump_target = 16'h0000;
    logic [15:0] pc, ifid_instr, ifid_pc_plus2;
    logic        ifid_valid, halted;

    logic [15:0] imem_addr_w, pc_w, ifid_instr_w, ifid_pc_plus2_w;
    logic        ifid_valid_w, halted_w;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetched, perf_stall, perf_fetched_w, perf_stall_w;
`endif

    logic [15:0] mem [0:31];

    int          n_vec = 0;
    int          n_err = 0;
    logic [32:0] sb[$];
    logic [32:0] exp_v, got_v;

    always #5 clk = ~clk;

    always_comb begin
        imem_data = 16'hDEAD;
        if (imem_addr < 16'd60) imem_data = mem[imem_addr[5:1]];
    end

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .pc            (pc),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus2 (ifid_pc_plus2),
        .ifid_valid    (ifid_valid),
        .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_stall    (perf_stall)
`endif
    );

    fetch_stage #(.RESET_PC(16'hFFFE)) dut_w (
        .clk           (clk),
        .reset         (rst_w),
        .imem_addr     (imem_addr_w),
        .imem_data     (16'h1234),
        .stall         (1'b0),
        .branch_taken  (1'b0),
        .branch_offset (8'h00),
        .jump_valid    (1'b0),
        .jump_target   (16'h0000),
        .pc            (pc_w),
        .ifid_instr    (ifid_instr_w),
        .ifid_pc_plus2 (ifid_pc_plus2_w),
        .ifid_valid    (ifid_valid_w),
        .halted        (halted_w)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched  (perf_fetched_w),
        .perf_stall    (perf_stall_w)
`endif
    );

    function automatic logic [15:0] word_at(input int i);
        case (i)
            0: return 16'h0120;
            1: return 16'h0121;
            2: return 16'h09E2;
            3: return 16'h0EF2;
            default: return 16'h1000 + 16'(i);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        n_vec++;
        if ({pc, ifid_instr, ifid_pc_plus2, ifid_valid, halted} !== {16'h0, 16'h0, 16'h0, 2'b00}) begin
            n_err++;
            $display("FAIL reset_state got pc=%h instr=%h pp2=%h v=%b h=%b want 0000/0000/0000/0/0",
                     pc, ifid_instr, ifid_pc_plus2, ifid_valid, halted);
        end
        n_vec++;
        if (imem_addr !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_addr got %h want 0000", imem_addr);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_fetch();
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (imem_addr !== 16'(2 * i)) begin
                n_err++;
                $display("FAIL fetch_addr%0d got %h want %h", i, imem_addr, 16'(2 * i));
            end
            sb.push_back({word_at(i), 16'(2 * i + 2), 1'b1});
            step();
            exp_v = sb.pop_front();
            got_v = {ifid_instr, ifid_pc_plus2, ifid_valid};
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL fetch_ifid%0d got %h want %h", i, got_v, exp_v);
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++;
            if ({pc, ifid_instr, ifid_pc_plus2, ifid_valid} !== {16'd4, 16'h0121, 16'd4, 1'b1}) begin
                n_err++;
                $display("FAIL stall_hold%0d got pc=%h instr=%h pp2=%h v=%b want 0004/0121/0004/1",
                         i, pc, ifid_instr, ifid_pc_plus2, ifid_valid);
            end
        end
        stall = 1'b0;
        for (int i = 2; i < 4; i++) begin
            sb.push_back({word_at(i), 16'(2 * i + 2), 1'b1});
            step();
            exp_v = sb.pop_front();
            got_v = {ifid_instr, ifid_pc_plus2, ifid_valid};
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL resume_ifid%0d got %h want %h", i, got_v, exp_v);
            end
        end
        n_vec++;
        if (pc !== 16'd8) begin
            n_err++;
            $display("FAIL resume_pc got %h want 0008", pc);
        end
    endtask

    task automatic test_branch_jump();
        branch_taken  = 1'b1;
        branch_offset = 8'hFE;
        step();
        branch_taken  = 1'b0;
        n_vec++;
        if ({pc, ifid_instr, ifid_valid} !== {16'd4, 16'h0000, 1'b0}) begin
            n_err++;
            $display("FAIL branch got pc=%h instr=%h v=%b want 0004/0000/0", pc, ifid_instr, ifid_valid);
        end
        stall       = 1'b1;
        jump_valid  = 1'b1;
        jump_target = 16'h0013;
        step();
        stall      = 1'b0;
        jump_valid = 1'b0;
        n_vec++;
        if ({pc, ifid_valid} !== {16'h0012, 1'b0}) begin
            n_err++;
            $display("FAIL jump_over_stall got pc=%h v=%b want 0012/0", pc, ifid_valid);
        end
    endtask

    task automatic test_range();
        for (int a = 18; a < 64; a += 2) begin
            n_vec++;
            if (pc !== 16'(a)) begin
                n_err++;
                $display("FAIL range_pc got %h want %h", pc, 16'(a));
            end
            sb.push_back({(a < 60) ? word_at(a / 2) : 16'h0000, 16'(a + 2), a < 60});
            step();
            exp_v = sb.pop_front();
            got_v = {ifid_instr, ifid_pc_plus2, ifid_valid};
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL range_ifid@%0d got %h want %h", a, got_v, exp_v);
            end
        end
    endtask

    task automatic test_wrap();
        rst_w = 1'b0;
        #2;
        n_vec++;
        if (pc_w !== 16'hFFFE) begin
            n_err++;
            $display("FAIL wrap_reset_pc got %h want fffe", pc_w);
        end
        @(negedge clk);
        rst_w = 1'b1;
        step();
        n_vec++;
        if ({pc_w, ifid_instr_w, ifid_pc_plus2_w, ifid_valid_w} !== {16'h0, 16'h0, 16'h0, 1'b0}) begin
            n_err++;
            $display("FAIL wrap_edge got pc=%h instr=%h pp2=%h v=%b want 0000/0000/0000/0",
                     pc_w, ifid_instr_w, ifid_pc_plus2_w, ifid_valid_w);
        end
        step();
        n_vec++;
        if ({pc_w, ifid_instr_w, ifid_pc_plus2_w, ifid_valid_w} !== {16'd2, 16'h1234, 16'd2, 1'b1}) begin
            n_err++;
            $display("FAIL wrap_fetch got pc=%h instr=%h pp2=%h v=%b want 0002/1234/0002/1",
                     pc_w, ifid_instr_w, ifid_pc_plus2_w, ifid_valid_w);
        end
    endtask

    task automatic test_halt();
        pulse_reset();
        mem[25]     = 16'hEFFF;
        jump_valid  = 1'b1;
        jump_target = 16'h0032;
        step();
        n_vec++;
        if ({pc, halted} !== {16'd50, 1'b0}) begin
            n_err++;
            $display("FAIL halt_jump got pc=%h h=%b want 0032/0", pc, halted);
        end
        // Jump while the halt word is on the bus: redirect must win.
        step();
        jump_valid = 1'b0;
        n_vec++;
        if ({pc, halted, ifid_valid} !== {16'd50, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL halt_redirect_wins got pc=%h h=%b v=%b want 0032/0/0", pc, halted, ifid_valid);
        end
        sb.push_back({16'hEFFF, 16'd52, 1'b1});
        step();
        exp_v = sb.pop_front();
        got_v = {ifid_instr, ifid_pc_plus2, ifid_valid};
        n_vec++;
        if ({got_v, pc, halted} !== {exp_v, 16'd50, 1'b1}) begin
            n_err++;
            $display("FAIL halt_latch got ifid=%h pc=%h h=%b want %h/0032/1", got_v, pc, halted, exp_v);
        end
        step();
        n_vec++;
        if ({ifid_instr, ifid_valid, pc, halted} !== {16'h0, 1'b0, 16'd50, 1'b1}) begin
            n_err++;
            $display("FAIL halt_nop got instr=%h v=%b pc=%h h=%b want 0000/0/0032/1",
                     ifid_instr, ifid_valid, pc, halted);
        end
        jump_valid    = 1'b1;
        jump_target   = 16'h0010;
        branch_taken  = 1'b1;
        branch_offset = 8'h04;
        step();
        jump_valid   = 1'b0;
        branch_taken = 1'b0;
        n_vec++;
        if ({pc, halted, ifid_valid} !== {16'd50, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL halt_ignores got pc=%h h=%b v=%b want 0032/1/0", pc, halted, ifid_valid);
        end
        #3;
        reset = 1'b0;
        #1;
        n_vec++;
        if ({pc, halted, ifid_valid, ifid_instr} !== {16'h0, 1'b0, 1'b0, 16'h0}) begin
            n_err++;
            $display("FAIL halt_async_reset got pc=%h h=%b v=%b instr=%h want 0000/0/0/0000",
                     pc, halted, ifid_valid, ifid_instr);
        end
        @(negedge clk);
        reset = 1'b1;
        step();
        n_vec++;
        if ({pc, ifid_instr, ifid_valid} !== {16'd2, 16'h0120, 1'b1}) begin
            n_err++;
            $display("FAIL restart got pc=%h instr=%h v=%b want 0002/0120/1", pc, ifid_instr, ifid_valid);
        end
        mem[25] = word_at(25);
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        pulse_reset();
        n_vec++;
        if ({perf_fetched, perf_stall} !== 32'h0) begin
            n_err++;
            $display("FAIL perf_reset got %h/%h want 0000/0000", perf_fetched, perf_stall);
        end
        for (int c = 0; c < 13; c++) begin
            stall = (c == 3 || c == 4 || c == 8);
            step();
        end
        stall = 1'b0;
        n_vec++;
        if ({perf_fetched, perf_stall} !== {16'd10, 16'd3}) begin
            n_err++;
            $display("FAIL perf_counts got %0d/%0d want 10/3", perf_fetched, perf_stall);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = word_at(i);
        test_reset();
        test_fetch();
        test_stall();
        test_branch_jump();
        test_range();
        test_wrap();
        test_halt();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
